// File: rtl/pc_hazard_ctrl.sv
// PC select and pipeline hazard control.
// Chooses the next PC (sequential, branch, jump or a redirect held across a
// memory freeze), generates stall/flush controls and counts redirects.
module pc_hazard_ctrl #(
  parameter int unsigned W          = 32,
  parameter int unsigned LU_BUBBLES = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         branch_taken_e,
  input  logic         jump_d,
  input  logic         load_use,
  input  logic         mem_busy,
  input  logic [W-1:0] pc_plus4,
  input  logic [W-1:0] branch_target,
  input  logic [W-1:0] jump_target,
  output logic [W-1:0] pc_next,
  output logic         pc_stall,
  output logic         flush_d,
  output logic         flush_e,
  output logic [15:0]  redirect_cnt
);

  typedef enum logic [1:0] {
    RUN,
    LU_STALL,
    MEM_WAIT
  } state_t;

  localparam logic [2:0] LU_RELOAD = 3'(LU_BUBBLES - 1);

  state_t         state, state_nx;
  logic           pend_valid, pend_valid_nx;
  logic           pend_branch, pend_branch_nx;
  logic [W-1:0]   pend_target, pend_target_nx;
  logic [2:0]     lu_cnt, lu_cnt_nx;

  logic [W-1:0]   pc_sel;
  logic           stall_c, flush_d_c, flush_e_c, redirect;
  logic           run_eval;

  // State registers; reset drops any pending redirect or bubble count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      pend_valid  <= 1'b0;
      pend_branch <= 1'b0;
      pend_target <= '0;
      lu_cnt      <= '0;
    end else begin
      state       <= state_nx;
      pend_valid  <= pend_valid_nx;
      pend_branch <= pend_branch_nx;
      pend_target <= pend_target_nx;
      lu_cnt      <= lu_cnt_nx;
    end
  end

  // Next-state and control decode with priority mem_busy > branch > jump > load-use.
  // States that fall back to normal RUN handling set run_eval, so the RUN
  // decision lives in one place.
  always_comb begin
    state_nx       = state;
    pend_valid_nx  = pend_valid;
    pend_branch_nx = pend_branch;
    pend_target_nx = pend_target;
    lu_cnt_nx      = lu_cnt;
    pc_sel         = pc_plus4;
    stall_c        = 1'b0;
    flush_d_c      = 1'b0;
    flush_e_c      = 1'b0;
    redirect       = 1'b0;
    run_eval       = 1'b0;

    case (state)
      RUN: run_eval = 1'b1;

      LU_STALL: begin
        if (mem_busy || branch_taken_e) begin
          // Freeze or branch abort: the remaining bubbles are abandoned.
          run_eval = 1'b1;
        end else begin
          stall_c   = 1'b1;
          flush_e_c = 1'b1;
          lu_cnt_nx = lu_cnt - 3'd1;
          if (lu_cnt == 3'd1) state_nx = RUN;
        end
      end

      MEM_WAIT: begin
        if (mem_busy) begin
          stall_c = 1'b1;
          if (branch_taken_e) begin
            pend_valid_nx  = 1'b1;
            pend_branch_nx = 1'b1;
            pend_target_nx = branch_target;
          end else if (jump_d && !pend_valid) begin
            pend_valid_nx  = 1'b1;
            pend_branch_nx = 1'b0;
            pend_target_nx = jump_target;
          end
        end else if (pend_valid) begin
          pc_sel        = pend_target;
          flush_d_c     = 1'b1;
          flush_e_c     = pend_branch;
          redirect      = 1'b1;
          pend_valid_nx = 1'b0;
          state_nx      = RUN;
        end else begin
          run_eval = 1'b1;
        end
      end

      default: state_nx = RUN;
    endcase

    if (run_eval) begin
      if (mem_busy) begin
        stall_c        = 1'b1;
        state_nx       = MEM_WAIT;
        pend_valid_nx  = branch_taken_e | jump_d;
        pend_branch_nx = branch_taken_e;
        if (branch_taken_e)   pend_target_nx = branch_target;
        else if (jump_d)      pend_target_nx = jump_target;
      end else if (branch_taken_e) begin
        pc_sel    = branch_target;
        flush_d_c = 1'b1;
        flush_e_c = 1'b1;
        redirect  = 1'b1;
        state_nx  = RUN;
      end else if (jump_d) begin
        pc_sel    = jump_target;
        flush_d_c = 1'b1;
        redirect  = 1'b1;
        state_nx  = RUN;
      end else if (load_use) begin
        stall_c   = 1'b1;
        flush_e_c = 1'b1;
        if (LU_BUBBLES > 1) begin
          lu_cnt_nx = LU_RELOAD;
          state_nx  = LU_STALL;
        end else begin
          state_nx  = RUN;
        end
      end else begin
        state_nx = RUN;
      end
    end
  end

  // Outputs are forced quiet while reset is held.
  always_comb begin
    pc_next  = reset ? '0   : pc_sel;
    pc_stall = reset ? 1'b0 : stall_c;
    flush_d  = reset ? 1'b0 : flush_d_c;
    flush_e  = reset ? 1'b0 : flush_e_c;
  end

  // Saturating count of cycles in which the PC takes a redirect target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_cnt <= '0;
    end else if (redirect && !stall_c && (redirect_cnt != '1)) begin
      redirect_cnt <= redirect_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pc_hazard_ctrl.sv
// Bench for pc_hazard_ctrl: directed vector table, multi-cycle corner
// sequences, randomized traffic against a reference model, counter saturation.
module tb_pc_hazard_ctrl;

  localparam int unsigned LUB = 3;
  localparam logic [31:0] P4 = 32'h0000_1004;
  localparam logic [31:0] BT = 32'h0000_0100;
  localparam logic [31:0] JT = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch_taken_e, jump_d, load_use, mem_busy;
  logic [31:0] pc_plus4, branch_target, jump_target;
  logic [31:0] pc_next;
  logic        pc_stall, flush_d, flush_e;
  logic [15:0] redirect_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  pc_hazard_ctrl #(.W(32), .LU_BUBBLES(LUB)) dut (
    .clk           (clk),
    .reset         (reset),
    .branch_taken_e(branch_taken_e),
    .jump_d        (jump_d),
    .load_use      (load_use),
    .mem_busy      (mem_busy),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .pc_next       (pc_next),
    .pc_stall      (pc_stall),
    .flush_d       (flush_d),
    .flush_e       (flush_e),
    .redirect_cnt  (redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit bt, input bit jd, input bit lu, input bit mb,
                       input logic [31:0] p4, input logic [31:0] btg, input logic [31:0] jtg);
    branch_taken_e = bt;
    jump_d         = jd;
    load_use       = lu;
    mem_busy       = mb;
    pc_plus4       = p4;
    branch_target  = btg;
    jump_target    = jtg;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string name, input logic [31:0] pc, input bit st,
                         input bit fd, input bit fe);
    chk({name, ".pc_next"},  pc_next,  pc);
    chk({name, ".pc_stall"}, {31'd0, pc_stall}, {31'd0, st});
    chk({name, ".flush_d"},  {31'd0, flush_d},  {31'd0, fd});
    chk({name, ".flush_e"},  {31'd0, flush_e},  {31'd0, fe});
  endtask

  // Reference model: mode 0 = running, 1 = load-use bubbles, 2 = frozen on memory.
  int          m_mode, m_left, m_cnt;
  bit          m_pend, m_pbr;
  logic [31:0] m_ptgt;
  int          n_mode, n_left, n_cnt;
  bit          n_pend, n_pbr;
  logic [31:0] n_ptgt;

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_cnt = 0; m_pend = 0; m_pbr = 0; m_ptgt = '0;
  endtask

  task automatic model_commit();
    m_mode = n_mode; m_left = n_left; m_cnt = n_cnt;
    m_pend = n_pend; m_pbr = n_pbr; m_ptgt = n_ptgt;
  endtask

  task automatic model_eval(input bit bt, input bit jd, input bit lu, input bit mb,
                            input logic [31:0] p4, input logic [31:0] btg, input logic [31:0] jtg,
                            output logic [31:0] e_pc, output bit e_st, output bit e_fd, output bit e_fe);
    bit normal;
    e_pc = p4; e_st = 0; e_fd = 0; e_fe = 0;
    n_mode = m_mode; n_left = m_left; n_cnt = m_cnt;
    n_pend = m_pend; n_pbr = m_pbr; n_ptgt = m_ptgt;
    normal = 0;
    if (m_mode == 2) begin
      if (mb) begin
        e_st = 1;
        if (bt) begin n_pend = 1; n_pbr = 1; n_ptgt = btg; end
        else if (jd && !m_pend) begin n_pend = 1; n_pbr = 0; n_ptgt = jtg; end
      end else if (m_pend) begin
        e_pc = m_ptgt; e_fd = 1; e_fe = m_pbr;
        n_pend = 0; n_mode = 0;
        if (n_cnt < 65535) n_cnt++;
      end else begin
        normal = 1;
      end
    end else if (m_mode == 1 && !mb && !bt) begin
      e_st = 1; e_fe = 1;
      n_left = m_left - 1;
      if (n_left == 0) n_mode = 0;
    end else begin
      normal = 1;
    end
    if (normal) begin
      if (mb) begin
        e_st = 1; n_mode = 2;
        n_pend = bt | jd; n_pbr = bt;
        if (bt) n_ptgt = btg; else if (jd) n_ptgt = jtg;
      end else if (bt) begin
        e_pc = btg; e_fd = 1; e_fe = 1; n_mode = 0;
        if (n_cnt < 65535) n_cnt++;
      end else if (jd) begin
        e_pc = jtg; e_fd = 1; n_mode = 0;
        if (n_cnt < 65535) n_cnt++;
      end else if (lu) begin
        e_st = 1; e_fe = 1;
        if (LUB > 1) begin n_mode = 1; n_left = LUB - 1; end
        else n_mode = 0;
      end else begin
        n_mode = 0;
      end
    end
  endtask

  typedef struct {
    bit          bt, jd, lu, mb;
    logic [31:0] pc;
    bit          st, fd, fe;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[18];

  initial begin
    logic [31:0] e_pc;
    bit          e_st, e_fd, e_fe;
    bit          rb, rj, rl, rm;
    logic [31:0] rp, rbt, rjt;

    tbl[0]  = '{0,0,0,0, P4, 0,0,0, 16'd0};
    tbl[1]  = '{1,1,0,0, BT, 0,1,1, 16'd0};  // branch beats jump
    tbl[2]  = '{0,0,0,0, P4, 0,0,0, 16'd1};
    tbl[3]  = '{0,1,1,0, JT, 0,1,0, 16'd1};  // jump beats load-use
    tbl[4]  = '{0,0,1,0, P4, 1,0,1, 16'd2};  // bubble 1 of 3
    tbl[5]  = '{0,0,0,0, P4, 1,0,1, 16'd2};  // bubble 2
    tbl[6]  = '{0,1,0,0, P4, 1,0,1, 16'd2};  // bubble 3, jump ignored
    tbl[7]  = '{0,0,0,0, P4, 0,0,0, 16'd2};
    tbl[8]  = '{0,0,1,0, P4, 1,0,1, 16'd2};
    tbl[9]  = '{1,0,0,0, BT, 0,1,1, 16'd2};  // branch aborts bubbles
    tbl[10] = '{0,0,0,0, P4, 0,0,0, 16'd3};
    tbl[11] = '{1,0,0,1, P4, 1,0,0, 16'd3};  // freeze, capture branch
    tbl[12] = '{0,1,0,1, P4, 1,0,0, 16'd3};  // jump ignored, branch pending
    tbl[13] = '{0,0,0,0, BT, 0,1,1, 16'd3};  // pending branch released
    tbl[14] = '{0,0,0,0, P4, 0,0,0, 16'd4};
    tbl[15] = '{0,0,0,1, P4, 1,0,0, 16'd4};  // freeze, nothing pending
    tbl[16] = '{0,1,0,0, JT, 0,1,0, 16'd4};  // unfreeze evaluates as running
    tbl[17] = '{0,0,0,0, P4, 0,0,0, 16'd5};

    // Reset with live inputs: outputs must stay quiet.
    reset = 1'b1;
    drive(1, 1, 1, 0, P4, BT, JT);
    tick();
    #4;
    chk_ctl("reset", 32'd0, 0, 0, 0);
    chk("reset.cnt", {16'd0, redirect_cnt}, 32'd0);
    tick();
    reset = 1'b0;
    drive(0, 0, 0, 0, P4, BT, JT);

    for (int unsigned i = 0; i < 18; i++) begin
      drive(tbl[i].bt, tbl[i].jd, tbl[i].lu, tbl[i].mb, P4, BT, JT);
      #4;
      chk_ctl($sformatf("vec%0d", i), tbl[i].pc, tbl[i].st, tbl[i].fd, tbl[i].fe);
      chk($sformatf("vec%0d.cnt", i), {16'd0, redirect_cnt}, {16'd0, tbl[i].cnt});
      tick();
    end

    // Four frozen cycles with a jump in the first, then release.
    for (int unsigned c = 0; c < 4; c++) begin
      drive(0, (c == 0), 0, 1, P4, BT, JT);
      #4;
      chk_ctl($sformatf("memjump.c%0d", c), P4, 1, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, P4, BT, JT);
    #4;
    chk_ctl("memjump.release", JT, 0, 1, 0);
    tick();

    // Pending jump overwritten by a branch while frozen.
    drive(0, 1, 0, 1, P4, 32'h80, JT);
    tick();
    drive(1, 0, 0, 1, P4, 32'h80, JT);
    tick();
    drive(0, 0, 0, 0, P4, 32'h80, JT);
    #4;
    chk_ctl("overwrite.release", 32'h80, 0, 1, 1);
    tick();

    // Asynchronous reset in the middle of a frozen cycle with a pending jump.
    drive(0, 1, 0, 1, P4, BT, JT);
    tick();
    drive(0, 0, 0, 1, P4, BT, JT);
    #2;
    reset = 1'b1;
    #1;
    chk_ctl("asyncrst", 32'd0, 0, 0, 0);
    chk("asyncrst.cnt", {16'd0, redirect_cnt}, 32'd0);
    #1;
    reset = 1'b0;
    drive(0, 0, 0, 0, P4, BT, JT);
    #1;
    chk_ctl("postrst.c0", P4, 0, 0, 0);
    tick();
    #4;
    chk_ctl("postrst.c1", P4, 0, 0, 0);
    chk("postrst.cnt", {16'd0, redirect_cnt}, 32'd0);
    tick();

    // Randomized traffic against the model.
    model_reset();
    for (int unsigned k = 0; k < 3000; k++) begin
      rm  = ($urandom_range(0, 99) < 25);
      rb  = ($urandom_range(0, 99) < 15);
      rj  = ($urandom_range(0, 99) < 20);
      rl  = ($urandom_range(0, 99) < 25);
      rp  = $urandom;
      rbt = $urandom;
      rjt = $urandom;
      drive(rb, rj, rl, rm, rp, rbt, rjt);
      #4;
      model_eval(rb, rj, rl, rm, rp, rbt, rjt, e_pc, e_st, e_fd, e_fe);
      chk_ctl($sformatf("rand%0d", k), e_pc, e_st, e_fd, e_fe);
      chk($sformatf("rand%0d.cnt", k), {16'd0, redirect_cnt}, m_cnt);
      tick();
      model_commit();
    end

    // Saturation of the redirect counter.
    drive(0, 0, 0, 0, P4, BT, JT);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1, 0, 0, 0, P4, BT, JT);
    for (int unsigned s = 0; s < 65534; s++) tick();
    chk("sat.below", {16'd0, redirect_cnt}, 32'h0000_FFFE);
    for (int unsigned s = 0; s < 6; s++) tick();
    chk("sat.hold", {16'd0, redirect_cnt}, 32'h0000_FFFF);
    drive(0, 0, 0, 0, P4, BT, JT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
